fir_sequencer: RTL and testbench

- Top-level control FSM for one FIR filter channel. Drives the coefficient address generator (reset_counter, incr_addr, init_in_progress) and the MAC accumulator.
- Runs two kinds of operation: coefficient-load (init) passes and per-sample MAC passes.
- Latches the filter configuration and manages the decimation/interpolation output cadence.
- Sits between the stream input/output handshakes and the FIR datapath.

---
 rtl/fir_sequencer.sv | 155 +++++++++++++++
 tb/tb_fir_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sequencer.sv
// fir_sequencer: control FSM for one FIR filter channel.
// Sequences coefficient-load passes and per-sample MAC passes, latches the
// filter configuration and paces the decimation/interpolation output cadence.
module fir_sequencer #(
    parameter int FS_WIDTH    = 6,
    parameter int PHASE_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_init,
    input  logic [FS_WIDTH-1:0] cfg_filter_size,
    input  logic [1:0]          cfg_dec_level,
    input  logic                cfg_downsample,
    input  logic                coeff_valid,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                last_coeff,
    output logic [FS_WIDTH-1:0] filter_size,
    output logic [1:0]          cur_dec_level,
    output logic                downsample,
    output logic                reset_counter,
    output logic                incr_addr,
    output logic                init_in_progress,
    output logic                coeff_we,
    output logic                acc_clear,
    output logic                acc_en,
    output logic                busy,
    output logic                init_done
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        READY,
        MAC,
        OUT
    } state_t;

    state_t                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [FS_WIDTH-1:0]    filterSize_q, filterSize_d;
    logic [1:0]             decLevel_q, decLevel_d;
    logic                   downsample_q, downsample_d;
    logic                   initDone_q, initDone_d;
    logic [PHASE_WIDTH-1:0] phaseMask;

    // Phase wraps at 2^L, so the last phase of a decimation group equals this mask
    always_comb begin
        phaseMask = PHASE_WIDTH'((32'd1 << decLevel_q) - 32'd1);
    end

    // State, phase, latched configuration and init-complete flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            filterSize_q <= '0;
            decLevel_q   <= '0;
            downsample_q <= 1'b0;
            initDone_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            filterSize_q <= filterSize_d;
            decLevel_q   <= decLevel_d;
            downsample_q <= downsample_d;
            initDone_q   <= initDone_d;
        end
    end

    // Next-state logic and per-state strobes to the address generator and MAC
    always_comb begin
        state_d          = state_q;
        phase_d          = phase_q;
        filterSize_d     = filterSize_q;
        decLevel_d       = decLevel_q;
        downsample_d     = downsample_q;
        initDone_d       = initDone_q;
        in_ready         = 1'b0;
        out_valid        = 1'b0;
        reset_counter    = 1'b0;
        incr_addr        = 1'b0;
        init_in_progress = 1'b0;
        coeff_we         = 1'b0;
        acc_clear        = 1'b0;
        acc_en           = 1'b0;

        case (state_q)
            IDLE: begin
                // Hold the address counter cleared, but keep every strobe low while reset is applied
                reset_counter = ~rst;
                if (start_init && (cfg_filter_size != '0)) begin
                    filterSize_d = cfg_filter_size;
                    decLevel_d   = cfg_dec_level;
                    downsample_d = cfg_downsample;
                    initDone_d   = 1'b0;
                    state_d      = INIT;
                end
            end
            INIT: begin
                init_in_progress = 1'b1;
                if (coeff_valid) begin
                    coeff_we  = 1'b1;
                    incr_addr = 1'b1;
                    if (last_coeff) begin
                        initDone_d    = 1'b1;
                        reset_counter = 1'b1;
                        phase_d       = '0;
                        state_d       = READY;
                    end
                end
            end
            READY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_clear     = 1'b1;
                    reset_counter = 1'b1;
                    state_d       = MAC;
                end else if (start_init) begin
                    state_d = IDLE;
                end
            end
            MAC: begin
                incr_addr = 1'b1;
                acc_en    = 1'b1;
                if (last_coeff) begin
                    phase_d = (phase_q + 1'b1) & phaseMask;
                    if (!downsample_q || (phase_q == phaseMask)) begin
                        state_d = OUT;
                    end else begin
                        state_d = READY;
                    end
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy          = (state_q != IDLE) && (state_q != READY);
    assign init_done     = initDone_q;
    assign filter_size   = filterSize_q;
    assign cur_dec_level = decLevel_q;
    assign downsample    = downsample_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: directed bench for fir_sequencer with a small
// address-counter model that produces last_coeff.
module tb_fir_sequencer;

    localparam int FS_WIDTH    = 6;
    localparam int PHASE_WIDTH = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                start_init;
    logic [FS_WIDTH-1:0] cfg_filter_size;
    logic [1:0]          cfg_dec_level;
    logic                cfg_downsample;
    logic                coeff_valid;
    logic                in_valid;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic                last_coeff;
    logic [FS_WIDTH-1:0] filter_size;
    logic [1:0]          cur_dec_level;
    logic                downsample;
    logic                reset_counter;
    logic                incr_addr;
    logic                init_in_progress;
    logic                coeff_we;
    logic                acc_clear;
    logic                acc_en;
    logic                busy;
    logic                init_done;

    int checks   = 0;
    int failures = 0;
    int addr;
    int limit;

    fir_sequencer #(
        .FS_WIDTH   (FS_WIDTH),
        .PHASE_WIDTH(PHASE_WIDTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_init      (start_init),
        .cfg_filter_size (cfg_filter_size),
        .cfg_dec_level   (cfg_dec_level),
        .cfg_downsample  (cfg_downsample),
        .coeff_valid     (coeff_valid),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .last_coeff      (last_coeff),
        .filter_size     (filter_size),
        .cur_dec_level   (cur_dec_level),
        .downsample      (downsample),
        .reset_counter   (reset_counter),
        .incr_addr       (incr_addr),
        .init_in_progress(init_in_progress),
        .coeff_we        (coeff_we),
        .acc_clear       (acc_clear),
        .acc_en          (acc_en),
        .busy            (busy),
        .init_done       (init_done)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Coefficient address counter: synchronous clear has priority over increment
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= 0;
        end else if (reset_counter) begin
            addr <= 0;
        end else if (incr_addr) begin
            addr <= addr + 1;
        end
    end

    // Final address: filter_size for loads and decimation, filter_size<<L for interpolation
    always_comb begin
        if (init_in_progress || downsample) begin
            limit = int'(filter_size);
        end else begin
            limit = int'(filter_size) << cur_dec_level;
        end
    end

    assign last_coeff = (addr == limit);

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic startInit, input logic coeffValid,
                                 input logic inValid, input logic outReady);
        start_init  = startInit;
        coeff_valid = coeffValid;
        in_valid    = inValid;
        out_ready   = outReady;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Start a coefficient load from IDLE and feed the valid pattern (bit 0 first)
    task automatic doInit(input int size, input int lvl, input logic ds,
                          input logic [15:0] pattern, input int len,
                          input int expWrites, input string tag);
        int writes;
        cfg_filter_size = FS_WIDTH'(size);
        cfg_dec_level   = 2'(lvl);
        cfg_downsample  = ds;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        #4;
        checkOutput({tag, "_idle_rc"}, int'(reset_counter), 1);
        nextCycle();
        start_init = 1'b0;
        writes = 0;
        for (int i = 0; i < len; i++) begin
            coeff_valid = pattern[i];
            #4;
            if (i == 0) begin
                checkOutput({tag, "_in_progress"}, int'(init_in_progress), 1);
                checkOutput({tag, "_done_cleared"}, int'(init_done), 0);
            end
            if (!pattern[i]) begin
                checkOutput({tag, "_stall_we"}, int'(coeff_we), 0);
                checkOutput({tag, "_stall_incr"}, int'(incr_addr), 0);
            end
            writes += int'(coeff_we);
            nextCycle();
        end
        coeff_valid = 1'b0;
        #4;
        checkOutput({tag, "_writes"}, writes, expWrites);
        checkOutput({tag, "_init_done"}, int'(init_done), 1);
        checkOutput({tag, "_ready"}, int'(in_ready), 1);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        nextCycle();
    endtask

    // Push one sample from READY and follow its MAC pass and optional output
    task automatic doSample(input logic expOut, input int expPass, input int holdCycles,
                            input logic toggleCfg, input string tag);
        int accs;
        int incrs;
        int cyc;
        logic done;
        applyStimulus(1'b0, 1'b0, 1'b1, (holdCycles == 0));
        #4;
        checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
        checkOutput({tag, "_acc_clear"}, int'(acc_clear), 1);
        nextCycle();
        in_valid = 1'b0;
        accs  = 0;
        incrs = 0;
        cyc   = 0;
        done  = 1'b0;
        while (!done) begin
            #4;
            if (in_ready || out_valid || cyc >= 100) begin
                done = 1'b1;
            end else begin
                accs  += int'(acc_en);
                incrs += int'(incr_addr);
                cyc++;
                if (toggleCfg && cyc == 2) begin
                    cfg_filter_size = 6'd5;
                    cfg_dec_level   = 2'd0;
                    cfg_downsample  = 1'b0;
                end
                if (toggleCfg && cyc == 4) begin
                    checkOutput({tag, "_cfg_size"}, int'(filter_size), 7);
                    checkOutput({tag, "_cfg_level"}, int'(cur_dec_level), 2);
                    checkOutput({tag, "_cfg_mode"}, int'(downsample), 1);
                end
                nextCycle();
            end
        end
        checkOutput({tag, "_pass_len"}, cyc, expPass);
        checkOutput({tag, "_acc_en"}, accs, expPass);
        checkOutput({tag, "_incr"}, incrs, expPass);
        checkOutput({tag, "_out_valid"}, int'(out_valid), int'(expOut));
        if (out_valid) begin
            checkOutput({tag, "_out_no_ready"}, int'(in_ready), 0);
            for (int h = 1; h < holdCycles; h++) begin
                nextCycle();
                #4;
                checkOutput({tag, "_hold_valid"}, int'(out_valid), 1);
                checkOutput({tag, "_hold_no_ready"}, int'(in_ready), 0);
            end
            if (holdCycles > 0) begin
                nextCycle();
                out_ready = 1'b1;
                #4;
                checkOutput({tag, "_hs_valid"}, int'(out_valid), 1);
            end
            nextCycle();
            #4;
            checkOutput({tag, "_ready_after_hs"}, int'(in_ready), 1);
        end
        out_ready = 1'b1;
        nextCycle();
    endtask

    initial begin
        rst             = 1'b1;
        cfg_filter_size = '0;
        cfg_dec_level   = '0;
        cfg_downsample  = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset state
        #12;
        checkOutput("rst_in_ready", int'(in_ready), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_init_done", int'(init_done), 0);
        checkOutput("rst_reset_counter", int'(reset_counter), 0);
        checkOutput("rst_filter_size", int'(filter_size), 0);
        nextCycle();
        rst = 1'b0;
        #4;
        checkOutput("idle_reset_counter", int'(reset_counter), 1);
        nextCycle();

        // Load 8 coefficients with a one-cycle gap (valid 1,1,0,1,1,1,1,1,1)
        doInit(7, 2, 1'b1, 16'h01FB, 9, 8, "init8");
        checkOutput("latched_size", int'(filter_size), 7);
        checkOutput("latched_level", int'(cur_dec_level), 2);
        checkOutput("latched_mode", int'(downsample), 1);

        // Decimate by 4: output after samples 4 and 8 only
        for (int k = 1; k <= 8; k++) begin
            doSample((k % 4) == 0, 8, 0, (k == 2), $sformatf("dec%0d", k));
        end

        // Reconfigure: start_init in READY goes back to IDLE first
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        #4;
        checkOutput("reconf_ready", int'(in_ready), 1);
        nextCycle();
        start_init = 1'b0;
        #4;
        checkOutput("reconf_idle_busy", int'(busy), 0);
        checkOutput("reconf_idle_ready", int'(in_ready), 0);
        checkOutput("reconf_idle_rc", int'(reset_counter), 1);
        nextCycle();

        // Interpolate by 2 with 4 taps: 7-cycle pass, output every sample
        doInit(3, 1, 1'b0, 16'h000F, 4, 4, "init4");
        for (int k = 1; k <= 3; k++) begin
            doSample(1'b1, 7, (k == 3) ? 5 : 0, 1'b0, $sformatf("int%0d", k));
        end

        // Async reset on cycle 3 of a MAC pass
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        nextCycle();
        in_valid = 1'b0;
        nextCycle();
        nextCycle();
        #1;
        checkOutput("mac3_acc_en", int'(acc_en), 1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arst_acc_en", int'(acc_en), 0);
        checkOutput("arst_incr", int'(incr_addr), 0);
        checkOutput("arst_busy", int'(busy), 0);
        checkOutput("arst_in_ready", int'(in_ready), 0);
        checkOutput("arst_out_valid", int'(out_valid), 0);
        checkOutput("arst_init_done", int'(init_done), 0);
        checkOutput("arst_rc", int'(reset_counter), 0);
        checkOutput("arst_filter_size", int'(filter_size), 0);
        nextCycle();
        rst = 1'b0;
        #4;
        checkOutput("post_rst_idle_rc", int'(reset_counter), 1);
        nextCycle();

        // start_init with a zero filter size is ignored
        cfg_filter_size = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        #4;
        checkOutput("fs0_busy", int'(busy), 0);
        checkOutput("fs0_in_progress", int'(init_in_progress), 0);
        checkOutput("fs0_coeff_we", int'(coeff_we), 0);
        checkOutput("fs0_in_ready", int'(in_ready), 0);
        checkOutput("fs0_init_done", int'(init_done), 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
